// File: rtl/adc_sd_emulator.sv
// rtl/adc_sd_emulator.sv - serial ADC emulator: shifts a zero-led conversion frame out under reader adc_clk/adc_cs
module adc_sd_emulator #(
  parameter int DATA_W     = 12,
  parameter int LEAD_ZEROS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              adc_clk,
  input  logic              adc_cs,
  output logic              adc_sd,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              overrun,
  output logic [7:0]        frame_count
);

  localparam int FRAME_LEN = LEAD_ZEROS + DATA_W;
  localparam int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t                 state_q, state_n;
  logic                   cs_s1, cs_s2, cs_d;
  logic                   ck_s1, ck_s2, ck_d;
  logic [DATA_W-1:0]      hold_q, hold_n;
  logic                   pending_q, pending_n;
  logic [FRAME_LEN-1:0]   shift_q, shift_n;
  logic [IDX_W-1:0]       idx_q, idx_n;
  logic                   sd_n, done_n, abort_n, overrun_n, capture;
  logic [7:0]             count_n;
  logic                   cs_fall, cs_rise, ck_fall;

  assign cs_fall = cs_d & ~cs_s2;
  assign cs_rise = ~cs_d & cs_s2;
  assign ck_fall = ck_d & ~ck_s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cs_s1       <= 1'b1;
      cs_s2       <= 1'b1;
      cs_d        <= 1'b1;
      ck_s1       <= 1'b0;
      ck_s2       <= 1'b0;
      ck_d        <= 1'b0;
      hold_q      <= '0;
      pending_q   <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      adc_sd      <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      state_q     <= state_n;
      cs_s1       <= adc_cs;
      cs_s2       <= cs_s1;
      cs_d        <= cs_s2;
      ck_s1       <= adc_clk;
      ck_s2       <= ck_s1;
      ck_d        <= ck_s2;
      hold_q      <= hold_n;
      pending_q   <= pending_n;
      shift_q     <= shift_n;
      idx_q       <= idx_n;
      adc_sd      <= sd_n;
      frame_done  <= done_n;
      frame_abort <= abort_n;
      overrun     <= overrun_n;
      frame_count <= count_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    shift_n   = shift_q;
    idx_n     = idx_q;
    done_n    = 1'b0;
    abort_n   = 1'b0;
    count_n   = frame_count;
    capture   = 1'b0;
    hold_n    = hold_q;
    pending_n = pending_q;
    overrun_n = 1'b0;
    sd_n      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_n = SHIFT;
          shift_n = FRAME_LEN'(hold_q);
          idx_n   = '0;
          capture = 1'b1;
        end
      end
      SHIFT: begin
        // Chip-select release outranks a simultaneous clock edge.
        if (cs_rise) begin
          state_n = IDLE;
          abort_n = 1'b1;
        end else if (ck_fall) begin
          if (idx_q == LAST_IDX) begin
            state_n = HOLD;
            done_n  = 1'b1;
            count_n = frame_count + 8'd1;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (cs_rise) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // A load on the capture edge is kept for the next frame; the frame took the old value.
    if (sample_valid) begin
      hold_n    = sample_data;
      pending_n = 1'b1;
      overrun_n = pending_q & ~capture;
    end else if (capture) begin
      pending_n = 1'b0;
    end

    if (state_n == SHIFT) sd_n = shift_n[LAST_IDX - idx_n];
  end

endmodule

// File: tb/tb_adc_sd_emulator.sv
// tb/tb_adc_sd_emulator.sv - directed self-checking bench for adc_sd_emulator
`timescale 1ns/1ps
module tb_adc_sd_emulator;

  logic        clk, reset_n, adc_clk, adc_cs, adc_sd;
  logic [11:0] sample_data;
  logic        sample_valid, frame_done, frame_abort, overrun;
  logic [7:0]  frame_count;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] exp_count = 8'd0;

  adc_sd_emulator #(.DATA_W(12), .LEAD_ZEROS(4)) dut (
    .clk(clk), .reset_n(reset_n), .adc_clk(adc_clk), .adc_cs(adc_cs), .adc_sd(adc_sd),
    .sample_data(sample_data), .sample_valid(sample_valid), .frame_done(frame_done),
    .frame_abort(frame_abort), .overrun(overrun), .frame_count(frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (frame_done)  done_cnt++;
    if (frame_abort) abort_cnt++;
    if (overrun)     ovr_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load(input logic [11:0] v);
    @(negedge clk);
    sample_data  = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    adc_cs = 1'b0;
    #100;
  endtask

  task automatic cs_high();
    adc_cs = 1'b1;
    #100;
  endtask

  // Reader behaviour: sample adc_sd as adc_clk rises, then drop adc_clk to advance.
  task automatic clock_bits(input int n, output logic [15:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      bits    = {bits[14:0], adc_sd};
      adc_clk = 1'b1;
      #50;
      adc_clk = 1'b0;
      #50;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; adc_clk = 1'b0; adc_cs = 1'b1;
    sample_data = '0; sample_valid = 1'b0;
    #23;
    checks++;
    if (adc_sd !== 1'b0 || frame_done !== 1'b0 || frame_abort !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got sd=%b done=%b abort=%b ovr=%b expected all 0", adc_sd, frame_done, frame_abort, overrun);
    end
    checks++;
    if (frame_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", frame_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #50;
  endtask

  task automatic test_frame();
    logic [15:0] bits;
    int d0;
    load(12'hA5C);
    d0 = done_cnt;
    cs_low();
    clock_bits(16, bits);
    #100;
    exp_count++;
    checks++;
    if (bits !== 16'h0A5C) begin
      errors++; $display("FAIL frame_bits: got %h expected 0a5c", bits);
    end
    checks++;
    if (adc_sd !== 1'b0) begin
      errors++; $display("FAIL frame_hold_sd: got %b expected 0", adc_sd);
    end
    checks++;
    if (done_cnt !== d0 + 1) begin
      errors++; $display("FAIL frame_done_pulses: got %0d expected 1", done_cnt - d0);
    end
    checks++;
    if (frame_count !== exp_count) begin
      errors++; $display("FAIL frame_count: got %0d expected %0d", frame_count, exp_count);
    end
    cs_high();
  endtask

  task automatic test_abort();
    logic [15:0] bits;
    int a0, d0;
    load(12'hFFF);
    a0 = abort_cnt; d0 = done_cnt;
    cs_low();
    clock_bits(8, bits);
    cs_high();
    checks++;
    if (bits[7:0] !== 8'h0F) begin
      errors++; $display("FAIL abort_bits: got %h expected 0f", bits[7:0]);
    end
    checks++;
    if (abort_cnt !== a0 + 1 || done_cnt !== d0) begin
      errors++; $display("FAIL abort_pulses: got abort=%0d done=%0d expected abort=1 done=0", abort_cnt - a0, done_cnt - d0);
    end
    checks++;
    if (frame_count !== exp_count || adc_sd !== 1'b0) begin
      errors++; $display("FAIL abort_state: got count=%0d sd=%b expected count=%0d sd=0", frame_count, adc_sd, exp_count);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] bits;
    int o0;
    o0 = ovr_cnt;
    load(12'h123);
    load(12'h456);
    #20;
    checks++;
    if (ovr_cnt !== o0 + 1) begin
      errors++; $display("FAIL overrun_pulses: got %0d expected 1", ovr_cnt - o0);
    end
    cs_low();
    clock_bits(16, bits);
    cs_high();
    exp_count++;
    checks++;
    if (bits !== 16'h0456) begin
      errors++; $display("FAIL overrun_frame_bits: got %h expected 0456", bits);
    end
    checks++;
    if (ovr_cnt !== o0 + 1) begin
      errors++; $display("FAIL overrun_extra: got %0d expected 1", ovr_cnt - o0);
    end
  endtask

  task automatic test_capture_collision();
    logic [15:0] bits;
    load(12'h001);
    @(negedge clk);
    adc_cs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sample_data  = 12'h7FF;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    #100;
    clock_bits(16, bits);
    cs_high();
    exp_count++;
    checks++;
    if (bits !== 16'h0001) begin
      errors++; $display("FAIL collision_first_bits: got %h expected 0001", bits);
    end
    cs_low();
    clock_bits(16, bits);
    cs_high();
    exp_count++;
    checks++;
    if (bits !== 16'h07FF) begin
      errors++; $display("FAIL collision_second_bits: got %h expected 07ff", bits);
    end
    checks++;
    if (frame_count !== exp_count) begin
      errors++; $display("FAIL collision_count: got %0d expected %0d", frame_count, exp_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] bits;
    int a0;
    load(12'h3C3);
    cs_low();
    clock_bits(6, bits);
    a0 = abort_cnt;
    checks++;
    if (adc_sd !== 1'b1) begin
      errors++; $display("FAIL midreset_bit6: got %b expected 1", adc_sd);
    end
    #3;
    reset_n = 1'b0;
    #1;
    exp_count = 8'd0;
    checks++;
    if (adc_sd !== 1'b0 || frame_done !== 1'b0 || frame_abort !== 1'b0 || overrun !== 1'b0 || frame_count !== 8'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got sd=%b done=%b abort=%b ovr=%b count=%0d expected all 0", adc_sd, frame_done, frame_abort, overrun, frame_count);
    end
    adc_cs = 1'b1;
    #50;
    @(negedge clk);
    reset_n = 1'b1;
    #100;
    checks++;
    if (abort_cnt !== a0) begin
      errors++; $display("FAIL midreset_no_abort: got %0d pulses expected 0", abort_cnt - a0);
    end
    load(12'h5A5);
    cs_low();
    clock_bits(16, bits);
    cs_high();
    exp_count++;
    checks++;
    if (bits !== 16'h05A5) begin
      errors++; $display("FAIL midreset_next_bits: got %h expected 05a5", bits);
    end
    checks++;
    if (frame_count !== exp_count) begin
      errors++; $display("FAIL midreset_count: got %0d expected %0d", frame_count, exp_count);
    end
  endtask

  task automatic test_wrap_and_hold();
    logic [15:0] bits;
    int d0;
    logic [7:0] start;
    start = exp_count;
    d0 = done_cnt;
    load(12'h9E1);
    for (int i = 0; i < 256; i++) begin
      cs_low();
      clock_bits(16, bits);
      #60;
      exp_count++;
      if (exp_count == 8'd0) begin
        checks++;
        if (frame_count !== 8'd0) begin
          errors++; $display("FAIL wrap_zero: got %0d expected 0 at frame %0d", frame_count, i);
        end
      end
      cs_high();
    end
    checks++;
    if (frame_count !== start || done_cnt !== d0 + 256) begin
      errors++; $display("FAIL wrap_total: got count=%0d done=%0d expected count=%0d done=256", frame_count, done_cnt - d0, start);
    end
    checks++;
    if (bits !== 16'h09E1) begin
      errors++; $display("FAIL wrap_last_bits: got %h expected 09e1", bits);
    end
    d0 = done_cnt;
    cs_low();
    clock_bits(16, bits);
    for (int i = 0; i < 10; i++) begin
      adc_clk = 1'b1;
      #50;
      checks++;
      if (adc_sd !== 1'b0) begin
        errors++; $display("FAIL hold_sd_rise: got %b expected 0 at edge %0d", adc_sd, 2 * i);
      end
      adc_clk = 1'b0;
      #50;
      checks++;
      if (adc_sd !== 1'b0) begin
        errors++; $display("FAIL hold_sd_fall: got %b expected 0 at edge %0d", adc_sd, 2 * i + 1);
      end
    end
    exp_count++;
    checks++;
    if (done_cnt !== d0 + 1 || frame_count !== exp_count) begin
      errors++; $display("FAIL hold_done: got done=%0d count=%0d expected done=1 count=%0d", done_cnt - d0, frame_count, exp_count);
    end
    cs_high();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_abort();
    test_overrun();
    test_capture_collision();
    test_reset_mid_frame();
    test_wrap_and_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sd_emulator.md
ADC_SD_EMULATOR -- requirements
Module: adc_sd_emulator

Interface
REQ-001 Parameter DATA_W, default 12: conversion result width.
REQ-002 Parameter LEAD_ZEROS, default 4: leading zero bits before the MSB; frame length FRAME_LEN = LEAD_ZEROS + DATA_W (16).
REQ-003 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port adc_clk, input, 1: serial clock from the ADC reader; asynchronous to clk.
REQ-006 Port adc_cs, input, 1: active-low chip select from the reader; asynchronous to clk.
REQ-007 Port adc_sd, output, 1: serial data to the reader.
REQ-008 Port sample_data, input, DATA_W: next conversion value.
REQ-009 Port sample_valid, input, 1: one-cycle load strobe for sample_data.
REQ-010 Port frame_done, output, 1: one-cycle pulse when a full frame has been shifted.
REQ-011 Port frame_abort, output, 1: one-cycle pulse when adc_cs deasserts mid-frame.
REQ-012 Port overrun, output, 1: one-cycle pulse when a loaded sample is overwritten before any frame used it.
REQ-013 Port frame_count, output, 8: count of completed frames, wraps 255 -> 0.

Function
REQ-014 adc_clk and adc_cs shall each pass through a 2-flop synchroniser; edge detection shall use the synchronised value and one further delayed copy.
REQ-015 Holding register: sample_valid loads sample_data on the same clk edge; a pending flag is set on load and cleared on frame capture.
REQ-016 overrun shall pulse when sample_valid arrives while pending is set; the new value replaces the old.
REQ-017 State machine: IDLE, SHIFT, HOLD.
REQ-018 IDLE -> SHIFT on detected adc_cs falling edge: capture {LEAD_ZEROS zeros, holding register} into the shift register, bit index = 0, clear pending.
REQ-019 If sample_valid coincides with the capture edge, the capture uses the pre-update holding value; the new value is marked pending for the next frame.
REQ-020 In SHIFT, adc_sd shall present shift-register bit FRAME_LEN-1-index (leading zeros, then data MSB first).
REQ-021 In SHIFT, each detected adc_clk falling edge shall increment the index; the edge taking index from FRAME_LEN-1 shall instead move to HOLD, drive adc_sd = 0, and pulse frame_done with frame_count incremented.
REQ-022 adc_clk rising edges shall not change state; the reader samples on them.
REQ-023 In HOLD, further adc_clk edges shall be ignored and adc_sd held 0; adc_cs rising edge -> IDLE.
REQ-024 In SHIFT, an adc_cs rising edge -> IDLE, adc_sd = 0, frame_abort pulse; frame_count unchanged.
REQ-025 If adc_cs rising and adc_clk falling are detected in the same cycle, adc_cs rising wins: no frame_done, and frame_abort pulses if in SHIFT.
REQ-026 adc_sd shall be 0 in IDLE and HOLD, and shall be registered (no combinational path from inputs).
REQ-027 Latency: adc_sd shall reflect the new bit 3 clk cycles after the adc_cs or adc_clk pin edge; correct operation requires clk >= 8x adc_clk.
REQ-028 adc_cs falling edges outside IDLE shall be ignored.

Reset
REQ-029 On reset_n low, asynchronously: state IDLE; adc_sd, frame_done, frame_abort, overrun = 0; frame_count = 0; holding and shift registers = 0; pending = 0; synchronisers = 1 for adc_cs and 0 for adc_clk.
REQ-030 Reset asserted mid-frame shall abandon the frame without a frame_abort pulse; after release, the first adc_cs falling edge seen shall start a clean frame.

Verification
REQ-031 Load 0xA5C, run 16 adc_clk falling edges, clk = 10x adc_clk -> reader bits 0000_1010_0101_1100, one frame_done, frame_count 0 -> 1.
REQ-032 Load 0xFFF, deassert adc_cs after 8 falling edges -> bits 0000_1111 seen, frame_abort pulse, frame_count unchanged, adc_sd = 0.
REQ-033 Load 0x123 then 0x456 with no frame between -> overrun pulse once; next frame returns 0x456.
REQ-034 sample_valid (0x7FF) in the same cycle as captured adc_cs fall with holding = 0x001 -> frame returns 0x001; next frame returns 0x7FF.
REQ-035 Run 256 complete frames -> frame_count wraps to 0; 20 extra adc_clk edges in HOLD leave adc_sd = 0.
REQ-036 Pulse reset_n low at bit 6 -> all outputs 0 immediately, no frame_abort; next frame correct.
